// File: rtl/sync_debouncer.sv
// Multi-channel input conditioner: a synchronizer chain per channel, then a saturating
// persistence counter that accepts a level only after it has held for DEBOUNCE_CYCLES cycles.
module sync_debouncer #(
   parameter int WIDTH           = 1,
   parameter int STAGES          = 3,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] chain_q [STAGES];
   logic [WIDTH-1:0] chain_d [STAGES];
   logic [CNT_W-1:0] cnt_q   [WIDTH];
   logic [CNT_W-1:0] cnt_d   [WIDTH];
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] differ;

   // Any agreeing cycle restarts the count; reaching CNT_MAX while still differing commits.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                 input logic             diff);
      if (!diff || (c == CNT_MAX))
         return '0;
      return c + CNT_W'(1);
   endfunction

   function automatic logic accept(input logic [CNT_W-1:0] c, input logic diff);
      return diff && (c == CNT_MAX);
   endfunction

   assign sync   = chain_q[STAGES-1];
   assign differ = sync ^ stable_q;

   always_comb begin
      chain_d[0] = in;
      for (int k = 1; k < STAGES; k++)
         chain_d[k] = chain_q[k-1];

      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_next(cnt_q[i], differ[i]);
         if (accept(cnt_q[i], differ[i]))
            stable_d[i] = sync[i];
      end

      // Edge pulses are registered alongside the level so they coincide with the new out value.
      rise_d = stable_d & ~stable_q;
      fall_d = ~stable_d & stable_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++)
            chain_q[k] <= '0;
         for (int i = 0; i < WIDTH; i++)
            cnt_q[i] <= '0;
         stable_q <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++)
            chain_q[k] <= chain_d[k];
         for (int i = 0; i < WIDTH; i++)
            cnt_q[i] <= cnt_d[i];
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign out  = stable_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: tb/tb_sync_debouncer.sv
// Table-driven bench for sync_debouncer: a 4-channel instance (STAGES=3, DEBOUNCE_CYCLES=4)
// and a minimal 1-channel instance (STAGES=2, DEBOUNCE_CYCLES=1).
module tb_sync_debouncer;

   typedef struct {
      string      name;
      logic       rst;
      logic [3:0] in;
      logic [3:0] out;
      logic [3:0] rise;
      logic [3:0] fall;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] in = 4'b0;
   logic [3:0] out, rise, fall;
   logic       reset2 = 1'b1;
   logic [0:0] in2 = 1'b0;
   logic [0:0] out2, rise2, fall2;

   vec_t tbl[$];
   vec_t tbl2[$];
   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   sync_debouncer #(.WIDTH(4), .STAGES(3), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .in(in), .out(out), .rise(rise), .fall(fall)
   );

   sync_debouncer #(.WIDTH(1), .STAGES(2), .DEBOUNCE_CYCLES(1)) dut2 (
      .clk(clk), .reset(reset2), .in(in2), .out(out2), .rise(rise2), .fall(fall2)
   );

   task automatic add(input int which, input string nm, input logic r, input logic [3:0] i,
                      input logic [3:0] o, input logic [3:0] ri, input logic [3:0] fa);
      vec_t v;
      v.name = nm; v.rst = r; v.in = i; v.out = o; v.rise = ri; v.fall = fa;
      if (which == 0) tbl.push_back(v);
      else            tbl2.push_back(v);
   endtask

   task automatic check(input int which);
      vec_t       e;
      logic [3:0] a_out, a_rise, a_fall;
      e = exp_q.pop_front();
      if (which == 0) begin
         a_out = out; a_rise = rise; a_fall = fall;
      end else begin
         a_out = {3'b0, out2}; a_rise = {3'b0, rise2}; a_fall = {3'b0, fall2};
      end
      n_vec++;
      if (a_out !== e.out || a_rise !== e.rise || a_fall !== e.fall) begin
         n_bad++;
         $display("FAIL %s (vector %0d): got out=%b rise=%b fall=%b, expected out=%b rise=%b fall=%b",
                  e.name, n_vec, a_out, a_rise, a_fall, e.out, e.rise, e.fall);
      end
   endtask

   task automatic apply(input int which);
      int   n;
      vec_t v;
      n = (which == 0) ? tbl.size() : tbl2.size();
      for (int k = 0; k < n; k++) begin
         v = (which == 0) ? tbl[k] : tbl2[k];
         @(negedge clk);
         if (which == 0) begin
            reset = v.rst; in = v.in;
         end else begin
            reset2 = v.rst; in2 = v.in[0];
         end
         exp_q.push_back(v);
         @(posedge clk);
         #1;
         check(which);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
      $fatal(1);
   end

   initial begin
      logic [3:0] i_v, o_v, r_v, f_v;
      logic       pat [20];
      logic       cur, prev;
      int         lc;
      int         s_up [4];
      int         s_dn [4];

      // Reset state, then a clean step on channel 0: visible after edge 7.
      add(0, "reset", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(0, "reset", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      for (int c = 1; c <= 10; c++)
         add(0, "clean_step", 1'b0, 4'b0001, (c >= 7) ? 4'b0001 : 4'b0000,
             (c == 7) ? 4'b0001 : 4'b0000, 4'b0000);

      // Three-cycle glitch on channel 1 is rejected.
      for (int c = 1; c <= 10; c++)
         add(0, "glitch3", 1'b0, (c <= 3) ? 4'b0011 : 4'b0001, 4'b0001, 4'b0000, 4'b0000);

      // Four-cycle pulse on channel 1 is accepted for exactly four cycles.
      for (int c = 1; c <= 12; c++)
         add(0, "pulse4", 1'b0, (c <= 4) ? 4'b0011 : 4'b0001,
             (c >= 7 && c <= 10) ? 4'b0011 : 4'b0001,
             (c == 7) ? 4'b0010 : 4'b0000, (c == 11) ? 4'b0010 : 4'b0000);

      // Bounce on channel 2 with runs of 1-2 cycles, ending high.
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
              1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      lc = 1;
      prev = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (pat[c-1] != prev) lc = c;
         prev = pat[c-1];
      end
      for (int c = 1; c <= 30; c++) begin
         cur = (c <= 20) ? pat[c-1] : 1'b1;
         i_v = {1'b0, cur, 2'b01};
         o_v = (c >= lc + 6) ? 4'b0101 : 4'b0001;
         r_v = (c == lc + 6) ? 4'b0100 : 4'b0000;
         add(0, "bounce", 1'b0, i_v, o_v, r_v, 4'b0000);
      end

      add(0, "reset_clear", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(0, "reset_clear", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Staggered rises and falls on all channels; each follows single-channel timing.
      s_up = '{1, 3, 2, 4};
      s_dn = '{15, 12, 14, 13};
      for (int c = 1; c <= 24; c++) begin
         for (int k = 0; k < 4; k++) begin
            i_v[k] = (c >= s_up[k]) && (c < s_dn[k]);
            o_v[k] = (c >= s_up[k] + 6) && (c < s_dn[k] + 6);
            r_v[k] = (c == s_up[k] + 6);
            f_v[k] = (c == s_dn[k] + 6);
         end
         add(0, "independence", 1'b0, i_v, o_v, r_v, f_v);
      end

      add(0, "reset_clear", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Reset five cycles into a count on channel 3; the change restarts after release.
      for (int c = 1; c <= 16; c++)
         add(0, "reset_midcount", (c == 6), 4'b1000, (c >= 13) ? 4'b1000 : 4'b0000,
             (c == 13) ? 4'b1000 : 4'b0000, 4'b0000);

      // Reset on the edge where the fall pulse would appear suppresses it.
      for (int c = 17; c <= 26; c++)
         add(0, "reset_midpulse", (c == 23), 4'b0000, (c < 23) ? 4'b1000 : 4'b0000,
             4'b0000, 4'b0000);

      // Minimal configuration: out follows after edge 3, single pulses.
      add(1, "min_reset", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add(1, "min_reset", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      for (int c = 1; c <= 9; c++)
         add(1, "min_corner", 1'b0, (c <= 4) ? 4'b0001 : 4'b0000,
             (c >= 3 && c < 7) ? 4'b0001 : 4'b0000,
             (c == 3) ? 4'b0001 : 4'b0000, (c == 7) ? 4'b0001 : 4'b0000);

      apply(0);
      apply(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sync_debouncer.md
SYNC_DEBOUNCER -- requirements
Module: sync_debouncer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 1, meaning the number of independent input channels.
REQ-002 The block SHALL take parameter STAGES, default 3, meaning the synchronizer flip-flop depth per channel; legal range is 2 or more.
REQ-003 The block SHALL take parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive cycles a synchronized change must persist before it is accepted; legal range is 1 or more.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 in  input  WIDTH  asynchronous raw inputs (buttons, switches), one bit per channel.
REQ-007 out  output  WIDTH  debounced, synchronized level per channel.
REQ-008 rise  output  WIDTH  one-cycle pulse per channel when out goes 0->1.
REQ-009 fall  output  WIDTH  one-cycle pulse per channel when out goes 1->0.

Function
REQ-010 Each channel SHALL be fully independent; no channel's state SHALL affect another channel.
REQ-011 Each channel SHALL pass in[i] through a chain of STAGES flip-flops; sync[i] denotes the last stage output.
REQ-012 No logic other than the next chain stage SHALL read any chain stage before the last one.
REQ-013 Each channel SHALL hold a stable register (driving out[i]) and a counter of width clog2(DEBOUNCE_CYCLES), with a minimum width of 1.
REQ-014 If sync[i] equals out[i], the counter SHALL load 0 on the next edge.
REQ-015 If sync[i] differs from out[i] and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-016 If sync[i] differs from out[i] and counter == DEBOUNCE_CYCLES-1, then on the next edge out[i] SHALL load sync[i] and the counter SHALL load 0.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-018 A mismatch interrupted by even one matching cycle SHALL restart the count from 0; glitches shorter than DEBOUNCE_CYCLES cycles at sync[i] SHALL never reach out[i].
REQ-019 Latency: a clean step on in[i] that is set up before edge 1 SHALL appear on out[i] after edge STAGES+DEBOUNCE_CYCLES.
REQ-020 rise[i] and fall[i] SHALL be registered outputs.
REQ-021 rise[i] SHALL be high for exactly the one cycle in which out[i] first shows its new value 1.
REQ-022 fall[i] SHALL be high for exactly the one cycle in which out[i] first shows its new value 0.
REQ-023 rise[i] and fall[i] SHALL never be high in the same cycle, and SHALL be low in every other cycle.
REQ-024 With DEBOUNCE_CYCLES=1, out[i] SHALL follow sync[i] with one cycle of additional delay, and REQ-021 and REQ-022 still apply.

Reset
REQ-025 While reset is high at a clock edge, every synchronizer stage, out, every counter, rise and fall SHALL load 0.
REQ-026 Reset asserted mid-count or mid-pulse SHALL discard the count and clear any pulse on that same edge.
REQ-027 After reset deasserts, an input that is held at 1 SHALL be treated as a new 0->1 change: rise SHALL pulse once, following the REQ-019 latency.
REQ-028 No output SHALL change other than on a clk rising edge.

Verification (WIDTH=4, STAGES=3, DEBOUNCE_CYCLES=4 unless stated)
REQ-029 Clean step: hold reset for 2 cycles, then set in=4'b0001 before edge 1 -> out=4'b0001 after edge 7, rise=4'b0001 for that one cycle only, fall=0 throughout.
REQ-030 Glitch rejection: pulse in[1] high for 3 cycles, then low -> out, rise and fall stay 0 throughout; a 4-cycle pulse -> out[1] goes high for 4 cycles, with exactly one rise pulse and one fall pulse.
REQ-031 Bounce: toggle in[2] at 1-2 cycle intervals for 20 cycles, then hold it at 1 -> exactly one rise[2] pulse, 7 cycles after the final transition; no fall[2] pulse.
REQ-032 Independence: change all 4 channels at staggered times within one debounce window -> each channel's out and pulse timing match a single-channel run; no cross-talk between channels.
REQ-033 Reset mid-count: in[3]=1, assert reset 5 cycles later, release it after 1 cycle -> out[3]=0 during reset; rise[3] asserts 7 cycles after release.
REQ-034 Parameter corner: STAGES=2, DEBOUNCE_CYCLES=1, WIDTH=1, step in -> out changes after edge 3, with a single rise pulse.
